// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: walks one ALU bit-slice LSB-first, one bit per clock,
// capturing carry-out, overflow and the SLT set bit on the MSB cycle.
module serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             v,
    output logic             c_out
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic             carry;
    logic [CNT_W-1:0] idx;
    logic             set_q;

    logic             last, bb, sum, cnext, slt;
    logic [WIDTH-1:0] r_fin;

    always_comb begin
        last  = (idx == CNT_W'(WIDTH - 1));
        bb    = b_q[idx] ^ op_q[2];
        sum   = a_q[idx] ^ bb ^ carry;
        cnext = (a_q[idx] & bb) | (a_q[idx] & carry) | (bb & carry);
        slt   = (op_q[1:0] == 2'b11);
        // SLT result is all zeros from RUN except bit 0, which takes the set bit.
        r_fin = r;
        if (slt) r_fin[0] = set_q;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            set_q <= 1'b0;
            r     <= '0;
            zero  <= 1'b0;
            v     <= 1'b0;
            c_out <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        carry <= op[2];
                        idx   <= '0;
                    end
                end
                RUN: begin
                    carry <= cnext;
                    idx   <= idx + CNT_W'(1);
                    case (op_q[1:0])
                        2'b00:   r[idx] <= a_q[idx] & bb;
                        2'b01:   r[idx] <= a_q[idx] | bb;
                        2'b10:   r[idx] <= sum;
                        default: r[idx] <= 1'b0;
                    endcase
                    if (last) begin
                        c_out <= cnext;
                        v     <= cnext ^ carry;
                        set_q <= sum ^ cnext ^ carry;
                    end
                end
                FIN: begin
                    r    <= r_fin;
                    zero <= ~|r_fin;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq: directed vectors, latency, restart,
// abort-by-reset and randomized ops against an arithmetic reference model.
module tb_serial_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, zero, v, c_out;
    logic [W-1:0] r;

    int n_cmp = 0;
    int n_err = 0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .r(r), .zero(zero), .v(v), .c_out(c_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic, no per-bit stepping.
    task automatic model(input logic [2:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                         output logic [W-1:0] er, output logic ez, output logic ev, output logic ec);
        logic [W-1:0] bx;
        logic [W:0]   s;
        logic         set;
        bx = mop[2] ? ~mb : mb;
        s  = {1'b0, ma} + {1'b0, bx} + {{W{1'b0}}, mop[2]};
        ec = s[W];
        ev = (ma[W-1] == bx[W-1]) && (s[W-1] != ma[W-1]);
        set = s[W-1] ^ ev;
        case (mop[1:0])
            2'b00:   er = ma & bx;
            2'b01:   er = ma | bx;
            2'b10:   er = s[W-1:0];
            default: er = {{(W-1){1'b0}}, set};
        endcase
        ez = (er == '0);
    endtask

    // Called just after a clock edge with start already driven; returns in the done cycle.
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!done && cnt < 100);
    endtask

    task automatic run_op(input logic [2:0] top, input logic [W-1:0] ta, input logic [W-1:0] tb_);
        int cnt;
        logic [W-1:0] er;
        logic ez, ev, ec;
        model(top, ta, tb_, er, ez, ev, ec);
        op = top; a = ta; b = tb_; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        a = $urandom; b = $urandom; op = 3'($urandom);
        cnt = 1;
        while (!done && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", cnt, 34);
        check("r", r, er);
        check("zero", zero, ez);
        check("v", v, ev);
        check("c_out", c_out, ec);
        @(posedge clk); #1;
        check("done_pulse", done, 1'b0);
        check("r_held", r, er);
    endtask

    task automatic run_dir(input logic [2:0] top, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic [W-1:0] exp_r);
        run_op(top, ta, tb_);
        check("dir_r", r, exp_r);
    endtask

    initial begin
        int cnt;
        int ndone;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_r", r, 0);
        check("rst_flags", {zero, v, c_out}, 3'b000);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        run_dir(3'b010, 32'd5, 32'd3, 32'd8);
        check("add_flags", {zero, v, c_out}, 3'b000);
        run_dir(3'b110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF);
        check("sub_vc", {v, c_out}, 2'b11);
        run_dir(3'b110, 32'd7, 32'd7, 32'd0);
        check("sub_zero", zero, 1'b1);
        run_dir(3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run_dir(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0);
        run_dir(3'b111, 32'd3, 32'd3, 32'd0);
        run_dir(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        run_dir(3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
        run_dir(3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hF000_F000);

        // Start held high with changing operands, then restart in the done cycle.
        op = 3'b010; a = 32'd100; b = 32'd23; start = 1'b1;
        @(posedge clk); #1;
        cnt = 1; ndone = 0;
        while (!done && cnt < 100) begin
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            cnt++;
            if (done) ndone++;
        end
        check("hold_latency", cnt, 34);
        check("hold_ndone", ndone, 1);
        check("hold_r", r, 123);
        check("done_cycle_busy", busy, 1'b0);
        a = 32'd1; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_busy", busy, 1'b1);
        cnt = 1;
        while (!done && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("restart_latency", cnt, 34);
        check("restart_r", r, 3);
        @(posedge clk); #1;

        // Abort mid-run at idx 10.
        op = 3'b010; a = 32'd5; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_r", r, 0);
        check("abort_flags", {busy, done, zero, v, c_out}, 5'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_op(3'b010, 32'd5, 32'd9);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom; rb = $urandom;
            if (i % 5 == 0) rb = ra;
            run_op(3'($urandom_range(0, 7)), ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
